// File: rtl/jedro_1_dmem_responder_if.sv
// LSU data-bus bundle between the load-store unit (master) and the data-memory responder (slave).
interface jedro_1_dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/jedro_1_dmem_responder.sv
// Data-memory endpoint for the LSU: byte-enabled word RAM, programmable wait states, one response per grant.
// Optional range checking with access-fault reporting is enabled by defining JEDRO_1_DMEM_RANGE_CHECK_EN.
module jedro_1_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8001_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  jedro_1_dmem_responder_if.slave dmem
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic        ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : (WAIT_CYCLES - 1));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [AW-1:0] r_idx;
  logic          r_in_range;
  logic          r_rvalid;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_gnt;
  logic          w_live;
  logic          w_access;
  logic          w_acc_we;
  logic [3:0]    w_acc_be;
  logic [31:0]   w_acc_wdata;
  logic [AW-1:0] w_acc_idx;
  logic          w_acc_in_range;

`ifdef JEDRO_1_DMEM_RANGE_CHECK_EN
  logic [29:0] w_idx_full;
  logic [32:0] w_addr_ext;
  logic [32:0] w_base_ext;
  logic [32:0] w_limit_ext;
  logic        w_unused_idx;

  // 33-bit compare so a region ending at the top of the address space does not wrap.
  assign w_idx_full   = dmem.addr_i[31:2] - BASE_ADDR[31:2];
  assign w_idx        = w_idx_full[AW-1:0];
  assign w_addr_ext   = {1'b0, dmem.addr_i};
  assign w_base_ext   = {1'b0, BASE_ADDR};
  assign w_limit_ext  = w_base_ext + 33'(DEPTH_WORDS * 4);
  assign w_in_range   = (w_addr_ext >= w_base_ext) && (w_addr_ext < w_limit_ext);
  assign w_unused_idx = ^w_idx_full[29:AW];
`else
  logic w_unused_addr;

  // Without the checker, addresses alias modulo the RAM size.
  assign w_idx         = dmem.addr_i[AW+1:2];
  assign w_in_range    = 1'b1;
  assign w_unused_addr = ^{dmem.addr_i[31:AW+2], dmem.addr_i[1:0]};
`endif

  assign w_gnt = dmem.req_i && (r_state == S_IDLE);
  assign w_live = (r_state == S_IDLE);

  // With zero wait states the access uses the live request at the grant edge.
  assign w_acc_we       = w_live ? dmem.we_i    : r_we;
  assign w_acc_be       = w_live ? dmem.be_i    : r_be;
  assign w_acc_wdata    = w_live ? dmem.wdata_i : r_wdata;
  assign w_acc_idx      = w_live ? w_idx        : r_idx;
  assign w_acc_in_range = w_live ? w_in_range   : r_in_range;
  assign w_access = !rst_i && ((w_gnt && ZERO_WAIT) || ((r_state == S_WAIT) && (r_cnt == 4'd0)));

  assign dmem.gnt_o    = w_gnt;
  assign dmem.rvalid_o = r_rvalid;
  assign dmem.rdata_o  = r_rdata;
  assign dmem.err_o    = r_err;

  // Byte-lane RAM write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (w_access && w_acc_we && w_acc_in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (w_acc_be[k]) begin
          r_mem[w_acc_idx][8*k +: 8] <= w_acc_wdata[8*k +: 8];
        end
      end
    end
  end

  // Transaction FSM, request latch and registered response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_idx      <= '0;
      r_in_range <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rvalid <= 1'b0;
          if (w_gnt) begin
            r_we       <= dmem.we_i;
            r_be       <= dmem.be_i;
            r_wdata    <= dmem.wdata_i;
            r_idx      <= w_idx;
            r_in_range <= w_in_range;
            if (ZERO_WAIT) begin
              r_state  <= S_RESP;
              r_rvalid <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state  <= S_RESP;
            r_rvalid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          r_rvalid <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_rvalid <= 1'b0;
        end
      endcase

      if (w_access) begin
        if (!w_acc_in_range) begin
          r_rdata <= 32'd0;
          r_err   <= 1'b1;
        end else if (w_acc_we) begin
          r_rdata <= 32'd0;
          r_err   <= 1'b0;
        end else begin
          r_rdata <= r_mem[w_acc_idx];
          r_err   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/jedro_1_dmem_responder.md
# jedro_1_dmem_responder

Memory-side endpoint of the core's load-store unit (LSU) data bus. It accepts word-addressed requests with byte enables, holds a synchronous word-organised data RAM, and returns one response per request after a configurable number of wait states. It also flags out-of-range accesses so the LSU can raise load or store access faults. It sits between the LSU data port and the SoC data-memory region.

## Interface
- DEPTH_WORDS, 4096: RAM size in 32-bit words; power of two.
- BASE_ADDR, 32'h8001_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_CYCLES, 1: extra cycles between grant and memory access; range 0..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; **one clock; reset is asynchronous and active-high**.
- req_i  in  1  request valid; held with all request fields until gnt_o.
- we_i  in  1  1 = store, 0 = load.
- be_i  in  4  byte enables for stores; ignored for loads.
- addr_i  in  32  byte address; bits [1:0] are ignored.
- wdata_i  in  32  store data, already lane-aligned by the LSU.
- gnt_o  out  1  request accepted this cycle (combinational).
- rvalid_o  out  1  one-cycle response pulse (registered).
- rdata_o  out  32  load data, valid with rvalid_o; 0 for stores and errors.
- err_o  out  1  access fault, valid with rvalid_o.

## Operation
- FSM states: IDLE, WAIT, RESP.
- gnt_o = req_i && state==IDLE. It is never asserted in WAIT or RESP, so at most one transaction is outstanding.
- Grant edge: latch we, be, wdata, and the word index addr_i[31:2]-BASE_ADDR[31:2], then compute in_range.
  - If WAIT_CYCLES==0, perform the access at this same edge and go to RESP.
  - Otherwise go to WAIT with cnt=WAIT_CYCLES-1.
- WAIT: if cnt==0, perform the access and go to RESP; otherwise cnt--.
- Access behaviour:
  - Store in range: write each byte lane k for which be[k]==1. be==4'b0000 writes nothing but still responds.
  - Load in range: rdata register <= RAM word.
  - Out of range: no RAM write; rdata register <= 0; err register <= 1.
- RESP: rvalid_o=1 for exactly one cycle, then IDLE. A new grant is possible in the cycle after RESP.
- in_range: addr_i >= BASE_ADDR && addr_i < BASE_ADDR + DEPTH_WORDS*4. The comparison uses 33-bit arithmetic, so no wrap occurs at 32'hFFFF_FFFF.

## Timing
- Reset values: rvalid_o=0, rdata_o=0, err_o=0, state=IDLE, cnt=0. gnt_o then follows req_i. RAM contents are not reset.
- Latency: response comes WAIT_CYCLES+1 cycles after the grant cycle. Grant in cycle N gives rvalid_o in cycle N+WAIT_CYCLES+1.
- Throughput: one transaction per WAIT_CYCLES+2 cycles under continuous req_i.
- rdata_o and err_o hold their values until the next access edge. They are only meaningful while rvalid_o=1.
- Request fields may change freely after the grant cycle; the latched copy is used.
- If req_i deasserts before gnt_o, nothing happens. The LSU must not do this, but the block tolerates it.
- Reset during WAIT: the transaction is dropped, no write is committed and no rvalid_o is produced.
- Reset during RESP: rvalid_o drops immediately (asynchronous).

## Configuration
- JEDRO_1_DMEM_RANGE_CHECK_EN defined:
  - range checking as above;
  - err_o=1 on out-of-range accesses;
  - out-of-range stores are suppressed.
- JEDRO_1_DMEM_RANGE_CHECK_EN undefined:
  - no comparator is built and err_o is tied to 0;
  - the word index is addr_i[$clog2(DEPTH_WORDS)+1:2], so addresses alias modulo the RAM size;
  - every access reaches the RAM.

## Test plan
- Word store, then load (WAIT_CYCLES=1): store 32'hDEAD_BEEF to 32'h8001_0010 with be=4'hF, then load the same address.
  - Required: gnt_o in the request cycle, rvalid_o 2 cycles later.
  - Load returns rdata_o=32'hDEAD_BEEF with err_o=0.
- Byte-lane store: start with the word at 32'h8001_0010 = 32'hDEAD_BEEF, store wdata=32'h1122_3344 with be=4'b0101, then load.
  - Required: rdata_o=32'hDE22_BE44.
- Out of range (macro defined): load from 32'h8000_FFFC, then store to BASE_ADDR+DEPTH_WORDS*4.
  - Required: both responses have err_o=1 and rdata_o=0; RAM is unchanged.
- Out of range (macro undefined): store 32'hA5A5_A5A5 to BASE_ADDR+DEPTH_WORDS*4, then load BASE_ADDR.
  - Required: the load returns 32'hA5A5_A5A5 with err_o=0.
- Back-to-back with WAIT_CYCLES=0: hold req_i high for 4 loads.
  - Required: gnt_o at cycles 0,2,4,6 and rvalid_o at cycles 1,3,5,7.
- Reset mid-store: set WAIT_CYCLES=3, store 32'hFFFF_FFFF to an address holding 0, and pulse rst_i one cycle after the grant.
  - Required: no rvalid_o; a later load returns 0.
